// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL dynamic phase-shift controller.
// Holds the FSM state encoding, the default parameter values and the
// width of the shared cycle counter. There are no ports.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PRST    = 3'd0,
        ST_WLOCK   = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SETUP   = 3'd3,
        ST_STEP_LO = 3'd4,
        ST_STEP_HI = 3'd5,
        ST_LOAD_LO = 3'd6,
        ST_SETTLE  = 3'd7
    } state_e;

    localparam int DEF_STEP_PULSE_CYC = 4;
    localparam int DEF_STEP_GAP_CYC   = 8;
    localparam int DEF_LOCK_FILTER    = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65535;
    localparam int DEF_RST_CYC        = 32;

    // One counter serves every timed state; it must hold LOCK_TIMEOUT-1.
    localparam int CYC_W     = 16;
    localparam int SETUP_CYC = 2;

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Command channel of the phase-shift controller.
// Signals: cmd_valid/cmd_ready handshake, cmd_sel (output select),
// cmd_dir (1=lag, 0=lead), cmd_steps (number of phase steps, 0..15).
//
// Handshake: a command transfers on a rising clk edge where both
// cmd_valid and cmd_ready are high. The master holds cmd_valid and the
// payload stable until that edge; cmd_ready never depends on cmd_valid.
interface pll_phase_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic       cmd_dir;
    logic [3:0] cmd_steps;

    modport master (output cmd_valid, cmd_sel, cmd_dir, cmd_steps, input cmd_ready);
    modport slave  (input cmd_valid, cmd_sel, cmd_dir, cmd_steps, output cmd_ready);
endinterface

// File: rtl/lock_filter.sv
// Synchronizes the asynchronous PLL LOCK signal and filters it.
// Ports: clk, rst (sync, active high), locked_async (raw PLL LOCK),
// stable (high once LOCK_FILTER consecutive synchronized-high cycles seen).
module lock_filter
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
    input  logic clk,
    input  logic rst,
    input  logic locked_async,
    output logic stable
);
    localparam int                CNT_W   = $clog2(LOCK_FILTER + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILTER);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    always_comb begin
        sync1_d = locked_async;
        sync2_d = sync1_q;
        cnt_d   = '0;
        if (sync2_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        // Registered copy of (counter == LOCK_FILTER), aligned with cnt_q.
        stable_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
endmodule

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift controller for a PLL, wired alongside the PLL.
// Ports: clk, rst (sync, active high), locked (async PLL LOCK),
// cmd (command channel, slave side), phasesel/phasedir/phasestep/
// phaseloadreg (to the PLL phase inputs, step/load idle high),
// pll_rst (PLL reset), stable (filtered lock), busy (not IDLE),
// err (one-cycle pulse per lock timeout), dbg_state (current FSM state).
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int STEP_PULSE_CYC = DEF_STEP_PULSE_CYC,
    parameter int STEP_GAP_CYC   = DEF_STEP_GAP_CYC,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int RST_CYC        = DEF_RST_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   locked,
    pll_phase_ctrl_if.slave        cmd,
    output logic [1:0]             phasesel,
    output logic                   phasedir,
    output logic                   phasestep,
    output logic                   phaseloadreg,
    output logic                   pll_rst,
    output logic                   stable,
    output logic                   busy,
    output logic                   err,
    output state_e                 dbg_state
);
    localparam logic [CYC_W-1:0] PULSE_LAST = CYC_W'(STEP_PULSE_CYC - 1);
    localparam logic [CYC_W-1:0] GAP_LAST   = CYC_W'(STEP_GAP_CYC - 1);
    localparam logic [CYC_W-1:0] TO_LAST    = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] RST_LAST   = CYC_W'(RST_CYC - 1);
    localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(SETUP_CYC - 1);

    logic stable_w;

    lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
        .clk          (clk),
        .rst          (rst),
        .locked_async (locked),
        .stable       (stable_w)
    );

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [3:0]       left_q, left_d;
    logic [1:0]       phasesel_q, phasesel_d;
    logic             phasedir_q, phasedir_d;
    logic             pll_rst_q, pll_rst_d;
    logic             phasestep_q, phasestep_d;
    logic             phaseloadreg_q, phaseloadreg_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q + CYC_W'(1);
        left_d     = left_q;
        phasesel_d = phasesel_q;
        phasedir_d = phasedir_q;
        err_d      = 1'b0;

        unique case (state_q)
            ST_PRST: begin
                if (cyc_q == RST_LAST) begin
                    state_d = ST_WLOCK;
                    cyc_d   = '0;
                end
            end
            // SETTLE is the post-load lock wait and shares WLOCK's timeout.
            ST_WLOCK, ST_SETTLE: begin
                if (stable_w) begin
                    state_d = ST_IDLE;
                    cyc_d   = '0;
                end else if (cyc_q == TO_LAST) begin
                    state_d = ST_PRST;
                    cyc_d   = '0;
                    err_d   = 1'b1;
                end
            end
            ST_IDLE: begin
                cyc_d = '0;
                // A presented command wins over a lock drop: ready was
                // already high, so the transfer has happened.
                if (cmd.cmd_valid && ready_q) begin
                    phasesel_d = cmd.cmd_sel;
                    phasedir_d = cmd.cmd_dir;
                    left_d     = cmd.cmd_steps;
                    state_d    = ST_SETUP;
                end else if (!stable_w) begin
                    state_d = ST_WLOCK;
                end
            end
            ST_SETUP: begin
                if (cyc_q == SETUP_LAST) begin
                    cyc_d   = '0;
                    state_d = (left_q == 4'd0) ? ST_LOAD_LO : ST_STEP_LO;
                end
            end
            ST_STEP_LO: begin
                if (cyc_q == PULSE_LAST) begin
                    cyc_d   = '0;
                    left_d  = left_q - 4'd1;
                    state_d = ST_STEP_HI;
                end
            end
            ST_STEP_HI: begin
                if (cyc_q == GAP_LAST) begin
                    cyc_d   = '0;
                    state_d = (left_q == 4'd0) ? ST_LOAD_LO : ST_STEP_LO;
                end
            end
            ST_LOAD_LO: begin
                if (cyc_q == PULSE_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_PRST;
                cyc_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered
        // outputs line up exactly with state_q.
        pll_rst_d      = (state_d == ST_PRST);
        phasestep_d    = (state_d != ST_STEP_LO);
        phaseloadreg_d = (state_d != ST_LOAD_LO);
        busy_d         = (state_d != ST_IDLE);
        ready_d        = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_PRST;
            cyc_q          <= '0;
            left_q         <= 4'd0;
            phasesel_q     <= 2'd0;
            phasedir_q     <= 1'b0;
            pll_rst_q      <= 1'b1;
            phasestep_q    <= 1'b1;
            phaseloadreg_q <= 1'b1;
            busy_q         <= 1'b1;
            ready_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cyc_q          <= cyc_d;
            left_q         <= left_d;
            phasesel_q     <= phasesel_d;
            phasedir_q     <= phasedir_d;
            pll_rst_q      <= pll_rst_d;
            phasestep_q    <= phasestep_d;
            phaseloadreg_q <= phaseloadreg_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            err_q          <= err_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign phasesel      = phasesel_q;
    assign phasedir      = phasedir_q;
    assign phasestep     = phasestep_q;
    assign phaseloadreg  = phaseloadreg_q;
    assign pll_rst       = pll_rst_q;
    assign stable        = stable_w;
    assign busy          = busy_q;
    assign err           = err_q;
    assign dbg_state     = state_q;
endmodule

// File: doc/pll_phase_ctrl.md
PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

Interface
REQ-001 SHALL have parameter STEP_PULSE_CYC, default 4: low-time of each phasestep pulse, in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter STEP_GAP_CYC, default 8: high-time after each phasestep pulse, in clk cycles (legal range 1..255).
REQ-003 SHALL have parameter LOCK_FILTER, default 16: consecutive synchronized-high locked cycles required to declare lock.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles spent waiting for lock before the PLL is reset.
REQ-005 SHALL have parameter RST_CYC, default 32: pll_rst assertion length, in clk cycles.
REQ-006 clk  in  1  PLL reference clock (50 MHz clkin); single clock domain.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 locked  in  1  PLL LOCK output; asynchronous to clk.
REQ-009 cmd_valid  in  1  phase-shift request.
REQ-010 cmd_ready  out  1  controller can accept a command.
REQ-011 cmd_sel  in  2  output select (0=CLKOP .. 3=CLKOS3).
REQ-012 cmd_dir  in  1  phase direction (1=lag, 0=lead).
REQ-013 cmd_steps  in  4  number of phase steps, 0..15.
REQ-014 phasesel  out  2  to PHASESEL1:0.
REQ-015 phasedir  out  1  to PHASEDIR.
REQ-016 phasestep  out  1  to PHASESTEP; idle high, active low.
REQ-017 phaseloadreg  out  1  to PHASELOADREG; idle high, active low.
REQ-018 pll_rst  out  1  to PLL RST; active high.
REQ-019 stable  out  1  filtered lock indication.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 err  out  1  one-cycle pulse on each lock timeout.

Function
REQ-022 locked SHALL pass through a 2-FF synchronizer; a lock counter SHALL saturate at LOCK_FILTER and clear to 0 on any synchronized-low cycle; stable = (counter == LOCK_FILTER).
REQ-023 The FSM states SHALL be PRST, WLOCK, IDLE, SETUP, STEP_LO, STEP_HI, LOAD_LO and SETTLE.
REQ-024 PRST: pll_rst=1 for RST_CYC cycles, then go to WLOCK.
REQ-025 WLOCK: a timeout counter counts cycles; when stable=1, go to IDLE; when the counter reaches LOCK_TIMEOUT first, pulse err, go to PRST, and clear the counter.
REQ-026 cmd_ready SHALL be 1 only when the state is IDLE; a command is accepted on the cycle where cmd_valid && cmd_ready; cmd_sel, cmd_dir and cmd_steps SHALL be registered on acceptance.
REQ-027 SETUP: drive phasesel and phasedir from the registered command for 2 cycles before the first pulse; phasesel and phasedir SHALL hold their values until the next acceptance.
REQ-028 STEP_LO/STEP_HI: phasestep=0 for STEP_PULSE_CYC cycles, then 1 for STEP_GAP_CYC cycles; repeat for cmd_steps pulses.
REQ-029 With cmd_steps=0, SETUP SHALL go directly to LOAD_LO, producing no phasestep pulse.
REQ-030 LOAD_LO: phaseloadreg=0 for STEP_PULSE_CYC cycles, then go to SETTLE.
REQ-031 SETTLE SHALL behave as WLOCK, including the timeout, and exit to IDLE once stable=1.
REQ-032 In IDLE, stable falling SHALL cause a transition to WLOCK without asserting pll_rst.
REQ-033 Loss of lock during SETUP/STEP/LOAD SHALL NOT abort the sequence; it is handled in SETTLE.
REQ-034 When an err pulse coincides with cmd_valid, the command SHALL NOT be accepted.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 While rst=1: state=PRST, counters=0, pll_rst=1, phasestep=1, phaseloadreg=1, phasesel=0, phasedir=0, stable=0, cmd_ready=0, busy=1, err=0, synchronizer=0.
REQ-037 On rst deassertion, PRST SHALL restart with a full RST_CYC count.
REQ-038 rst asserted mid-sequence SHALL abort the sequence immediately, with no partial pulse completion.

Structure
REQ-039 The FSM state encoding and default parameter constants SHALL live in shared package pll_ctrl_pkg.
REQ-040 The synchronizer and lock filter SHALL form one sub-module, lock_filter (ports clk, rst, locked_async, stable).
REQ-041 The implementation SHALL NOT instantiate the PLL; it is wired alongside it at the top level.

Verification
REQ-042 Reset release with locked=1 from cycle 0 -> pll_rst high for exactly 32 cycles, stable rises 2+16 cycles after lock is seen, cmd_ready=1.
REQ-043 Command sel=2, dir=1, steps=3 -> phasesel=2, phasedir=1; 3 low pulses of 4 cycles separated by 8 high cycles; one 4-cycle phaseloadreg low pulse; return to IDLE.
REQ-044 steps=0 -> no phasestep pulse, a single phaseloadreg pulse, back in IDLE.
REQ-045 locked held at 0 with LOCK_TIMEOUT=100 -> err pulses every 100+32 cycles, pll_rst re-asserted each time.
REQ-046 locked glitching low for 1 cycle in IDLE -> stable drops, WLOCK entered, no pll_rst, IDLE regained after 16 clean cycles.
REQ-047 rst asserted during the second STEP_LO -> phasestep=1 on the next cycle, state=PRST, cmd_ready=0.
